// File: rtl/shift_seq_pkg.sv
// Shared encodings for the iterative shift sequencer: operation codes and FSM states.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step; the sequencer applies it once per clock.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (op)
      OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
      OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
      OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
      OP_ROTR: dout = {din[0], din[WIDTH-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable-amount shifter: one bit per clock under a start/busy/done handshake.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  state_e             state_q, state_d;
  op_e                op_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   step_out;
  logic [SHAMT_W-1:0] count_q;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;
  logic               done_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op   (op_q),
    .din  (work_q),
    .dout (step_out)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (shamt == SHAMT_W'(0)) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (count_q == SHAMT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs; result only moves on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_SLL;
      work_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q <= op_e'(op);
            if (shamt == SHAMT_W'(0)) begin
              result_q <= data_in;
            end else begin
              work_q  <= data_in;
              count_q <= shamt;
            end
          end
        end
        S_SHIFT: begin
          work_q  <= step_out;
          count_q <= count_q - SHAMT_W'(1);
          if (count_q == SHAMT_W'(1)) begin
            result_q <= step_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
